// File: rtl/uart_autobaud.sv
`default_nettype none
// ============================================================================
// Module  : uart_autobaud
// Times a 0x55 sync character on rx_i and reports the cycles-per-bit divisor.
// Option  : define AUTOBAUD_TIMEOUT_EN to abort on a missing falling edge.
// Rev     : 1.0
// ============================================================================
module uart_autobaud #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned DEF_DIV   = 868,
    parameter int unsigned MIN_DIV   = 16
`ifdef AUTOBAUD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = 2**20
`endif
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 start_i,
    input  logic                 rx_i,
    output logic [CNT_WIDTH-1:0] div_o,
    output logic                 div_valid_o,
    output logic                 busy_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [CNT_WIDTH-1:0] C_DEF_DIV  = CNT_WIDTH'(DEF_DIV);
    localparam logic [CNT_WIDTH-1:0] C_MIN_DIV  = CNT_WIDTH'(MIN_DIV);
    localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);
`ifdef AUTOBAUD_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] C_TIMEOUT  = CNT_WIDTH'(TIMEOUT);
`endif

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic                   prev_q, prev_d;
    logic [CNT_WIDTH-1:0]   span_q, span_d;
    logic [CNT_WIDTH-1:0]   ival_q, ival_d;
    logic [CNT_WIDTH-1:0]   i0_q, i0_d;
    logic [1:0]             edge_cnt_q, edge_cnt_d;
    logic [CNT_WIDTH-1:0]   div_q, div_d;
    logic                   div_valid_q, div_valid_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic                   w_fall;
    logic [CNT_WIDTH-1:0]   w_span_inc;
    logic [CNT_WIDTH-1:0]   w_ival_inc;
    logic [CNT_WIDTH-1:0]   w_ival_diff;
    logic                   w_ival_ok;
    logic [CNT_WIDTH:0]     w_sum;
    logic [CNT_WIDTH-1:0]   w_res;

    always_comb begin
        sync1_d = rx_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    assign w_fall      = prev_q & ~sync2_q;
    // Counters advance on every MEASURE cycle, including the one a fall lands on.
    assign w_span_inc  = span_q + C_ONE;
    assign w_ival_inc  = ival_q + C_ONE;
    assign w_ival_diff = (w_ival_inc >= i0_q) ? (w_ival_inc - i0_q) : (i0_q - w_ival_inc);
    assign w_ival_ok   = (w_ival_diff <= (i0_q >> 2));
    assign w_sum       = {1'b0, w_span_inc} + (CNT_WIDTH+1)'(4);
    assign w_res       = CNT_WIDTH'(w_sum >> 3);

    always_comb begin
        state_d     = state_q;
        span_d      = span_q;
        ival_d      = ival_q;
        i0_d        = i0_q;
        edge_cnt_d  = edge_cnt_q;
        div_d       = div_q;
        div_valid_d = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_fall) begin
                    state_d    = ST_MEASURE;
                    span_d     = '0;
                    ival_d     = '0;
                    edge_cnt_d = 2'd0;
                end
            end
            ST_MEASURE: begin
                span_d = w_span_inc;
                ival_d = w_ival_inc;
                if ((w_span_inc == C_ALL_ONES) || (w_ival_inc == C_ALL_ONES)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (w_fall) begin
                    if (edge_cnt_q == 2'd0) begin
                        i0_d       = w_ival_inc;
                        ival_d     = '0;
                        edge_cnt_d = 2'd1;
                    end else if (!w_ival_ok) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ival_d     = '0;
                        edge_cnt_d = edge_cnt_q + 2'd1;
                        // Fourth interval closes the E0->E4 span of eight bit times.
                        if (edge_cnt_q == 2'd3) begin
                            state_d = ST_IDLE;
                            if (w_res < C_MIN_DIV) begin
                                err_d = 1'b1;
                            end else begin
                                div_d       = w_res;
                                div_valid_d = 1'b1;
                            end
                        end
                    end
                end
`ifdef AUTOBAUD_TIMEOUT_EN
                else if (w_ival_inc >= C_TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            span_q      <= '0;
            ival_q      <= '0;
            i0_q        <= '0;
            edge_cnt_q  <= 2'd0;
            div_q       <= C_DEF_DIV;
            div_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            span_q      <= span_d;
            ival_q      <= ival_d;
            i0_q        <= i0_d;
            edge_cnt_q  <= edge_cnt_d;
            div_q       <= div_d;
            div_valid_q <= div_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign div_o       = div_q;
    assign div_valid_o = div_valid_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_autobaud
// Scoreboarded bench for uart_autobaud; result events are queued by a monitor.
// Rev     : 1.0
// ============================================================================
module tb_uart_autobaud;

    typedef struct packed {
        logic        err;
        logic        val;
        logic        busy;
        logic [31:0] div;
    } obs_t;

    typedef struct packed {
        logic        err;
        logic [31:0] div;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start_i;
    logic        rx_i;
    logic [31:0] div_o;
    logic        div_valid_o;
    logic        busy_o;
    logic        err_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t obs_q[$];
    exp_t exp_q[$];

`ifdef AUTOBAUD_TIMEOUT_EN
    localparam int TB_TIMEOUT = 2000;
    uart_autobaud #(.CNT_WIDTH(32), .DEF_DIV(868), .MIN_DIV(16), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk_i(clk), .arst_ni(arst_n), .start_i(start_i), .rx_i(rx_i),
        .div_o(div_o), .div_valid_o(div_valid_o), .busy_o(busy_o), .err_o(err_o)
    );
`else
    uart_autobaud #(.CNT_WIDTH(32), .DEF_DIV(868), .MIN_DIV(16)) dut (
        .clk_i(clk), .arst_ni(arst_n), .start_i(start_i), .rx_i(rx_i),
        .div_o(div_o), .div_valid_o(div_valid_o), .busy_o(busy_o), .err_o(err_o)
    );
`endif

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (arst_n && (err_o || div_valid_o))
            obs_q.push_back('{err_o, div_valid_o, busy_o, div_o});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bpc);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = frame[i];
            repeat (bpc) @(negedge clk);
        end
    endtask

    // Five falling edges separated by the four given intervals.
    task automatic send_falls(input int a, input int b, input int c, input int d);
        int iv[4];
        iv = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            rx_i = 1'b0;
            repeat (20) @(negedge clk);
            rx_i = 1'b1;
            repeat (iv[i] - 20) @(negedge clk);
        end
        rx_i = 1'b0;
        repeat (20) @(negedge clk);
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic wait_event(input int limit, output bit ok);
        int n;
        n = 0;
        while (obs_q.size() == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = (obs_q.size() != 0);
    endtask

    task automatic test_reset();
        arst_n  = 1'b0;
        start_i = 1'b0;
        rx_i    = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (div_o !== 32'd868) begin n_fail++; $display("FAIL reset_div: div_o=%0d expected 868", div_o); end
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy_o=%0b expected 0", busy_o); end
        n_checks++;
        if (div_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: div_valid_o=%0b expected 0", div_valid_o); end
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: err_o=%0b expected 0", err_o); end
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_measure_80();
        bit ok; obs_t o; exp_t e;
        pulse_start();
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL t80_busy_armed: busy_o=%0b expected 1", busy_o); end
        pulse_start();
        exp_q.push_back('{1'b0, 32'd80});
        send_byte(8'h55, 80);
        wait_event(200, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL t80_event: no event seen, expected div_valid with div=%0d", e.div);
        end else begin
            o = obs_q.pop_front();
            if (o.err !== e.err || o.val !== !e.err || o.div !== e.div) begin
                n_fail++; $display("FAIL t80_event: err=%0b valid=%0b div=%0d, expected err=%0b div=%0d", o.err, o.val, o.div, e.err, e.div);
            end
            n_checks++;
            if (o.busy !== 1'b0) begin n_fail++; $display("FAIL t80_busy_drop: busy_o=%0b with div_valid, expected 0", o.busy); end
        end
    endtask

    task automatic test_measure_83_and_bad_pattern();
        bit ok; obs_t o; exp_t e;
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            if (k == 0) begin
                exp_q.push_back('{1'b0, 32'd83});
                send_byte(8'h55, 83);
            end else begin
                exp_q.push_back('{1'b1, 32'd83});
                send_byte(8'h0F, 40);
                send_byte(8'h55, 40);
            end
            wait_event(200, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL t83_event[%0d]: no event seen, expected err=%0b div=%0d", k, e.err, e.div);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || o.val !== !e.err || o.div !== e.div) begin
                    n_fail++; $display("FAIL t83_event[%0d]: err=%0b valid=%0b div=%0d, expected err=%0b div=%0d", k, o.err, o.val, o.div, e.err, e.div);
                end
            end
        end
        n_checks++;
        if (div_o !== 32'd83) begin n_fail++; $display("FAIL t83_div_hold: div_o=%0d expected 83", div_o); end
    endtask

    task automatic test_min_div();
        bit ok; obs_t o; exp_t e;
        int   bpc[3]  = '{10, 16, 15};
        logic xerr[3] = '{1'b1, 1'b0, 1'b1};
        int   xdiv[3] = '{83, 16, 16};
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            exp_q.push_back('{xerr[k], 32'(xdiv[k])});
            send_byte(8'h55, bpc[k]);
            wait_event(100, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL min_div[%0d]: no event seen, expected err=%0b div=%0d", bpc[k], e.err, e.div);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || o.val !== !e.err || o.div !== e.div) begin
                    n_fail++; $display("FAIL min_div[%0d]: err=%0b valid=%0b div=%0d, expected err=%0b div=%0d", bpc[k], o.err, o.val, o.div, e.err, e.div);
                end
            end
        end
    endtask

    task automatic test_tolerance_rounding();
        bit ok; obs_t o; exp_t e;
        int tv[6][4] = '{'{160, 200, 160, 160}, '{160, 201, 160, 160}, '{161, 161, 161, 161},
                         '{161, 161, 161, 160}, '{160, 120, 160, 160}, '{160, 160, 160, 210}};
        logic xerr[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int   xdiv[6] = '{85, 85, 81, 80, 75, 75};
        for (int k = 0; k < 6; k++) begin
            pulse_start();
            exp_q.push_back('{xerr[k], 32'(xdiv[k])});
            send_falls(tv[k][0], tv[k][1], tv[k][2], tv[k][3]);
            wait_event(100, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL tol[%0d]: no event seen, expected err=%0b div=%0d", k, e.err, e.div);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || o.val !== !e.err || o.div !== e.div) begin
                    n_fail++; $display("FAIL tol[%0d]: err=%0b valid=%0b div=%0d, expected err=%0b div=%0d", k, o.err, o.val, o.div, e.err, e.div);
                end
            end
        end
    endtask

    task automatic test_rx_low_armed();
        bit ok; obs_t o; exp_t e;
        @(negedge clk);
        rx_i = 1'b0;
        repeat (50) @(negedge clk);
        pulse_start();
        repeat (200) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL rx_low_armed: busy_o=%0b events=%0d, expected busy 1 and no events", busy_o, obs_q.size());
        end
        rx_i = 1'b1;
        repeat (100) @(negedge clk);
        exp_q.push_back('{1'b0, 32'd64});
        send_byte(8'h55, 64);
        wait_event(100, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rx_low_event: no event seen, expected div=%0d", e.div);
        end else begin
            o = obs_q.pop_front();
            if (o.err !== e.err || o.val !== !e.err || o.div !== e.div) begin
                n_fail++; $display("FAIL rx_low_event: err=%0b valid=%0b div=%0d, expected err=%0b div=%0d", o.err, o.val, o.div, e.err, e.div);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; obs_t o; exp_t e;
        int bpc[2] = '{30, 100};
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            exp_q.push_back('{1'b0, 32'(bpc[k])});
            fork
                send_byte(8'h55, bpc[k]);
                begin
                    repeat (100) @(negedge clk);
                    start_i = 1'b1;
                    @(negedge clk);
                    start_i = 1'b0;
                end
            join
            wait_event(100, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL b2b[%0d]: no event seen, expected div=%0d", k, e.div);
            end else begin
                o = obs_q.pop_front();
                if (o.err !== e.err || o.val !== !e.err || o.div !== e.div) begin
                    n_fail++; $display("FAIL b2b[%0d]: err=%0b valid=%0b div=%0d, expected err=%0b div=%0d", k, o.err, o.val, o.div, e.err, e.div);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: %0d extra events, expected 0", obs_q.size()); end
    endtask

    task automatic test_timeout();
        obs_t o;
        int   n;
        pulse_start();
        n = 0;
        rx_i = 1'b0;
`ifdef AUTOBAUD_TIMEOUT_EN
        while (obs_q.size() == 0 && n < TB_TIMEOUT + 200) begin
            @(negedge clk);
            n++;
            if (n == 20) rx_i = 1'b1;
        end
        rx_i = 1'b1;
        n_checks++;
        if (obs_q.size() == 0) begin
            n_fail++; $display("FAIL timeout_event: no event after %0d cycles, expected err near %0d", n, TB_TIMEOUT);
        end else begin
            o = obs_q.pop_front();
            if (o.err !== 1'b1 || o.val !== 1'b0 || o.div !== 32'd100) begin
                n_fail++; $display("FAIL timeout_event: err=%0b valid=%0b div=%0d, expected err=1 div=100", o.err, o.val, o.div);
            end
            n_checks++;
            if (n < TB_TIMEOUT || n > TB_TIMEOUT + 4) begin
                n_fail++; $display("FAIL timeout_time: err after %0d cycles, expected %0d..%0d", n, TB_TIMEOUT, TB_TIMEOUT + 4);
            end
        end
`else
        repeat (20) @(negedge clk);
        rx_i = 1'b1;
        repeat (3000) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL timeout_stall: busy_o=%0b events=%0d, expected busy 1 and no events", busy_o, obs_q.size());
        end
        pulse_start();
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL timeout_restart: busy_o=%0b events=%0d, expected busy 1 and no events", busy_o, obs_q.size());
        end
        #3 arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL timeout_reset: busy_o=%0b expected 0", busy_o); end
`endif
    endtask

    task automatic test_reset_rearm();
        bit ok; obs_t o; exp_t e;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            rx_i = 1'b0;
            repeat (20) @(negedge clk);
            rx_i = 1'b1;
            repeat (140) @(negedge clk);
        end
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rearm_busy_mid: busy_o=%0b expected 1", busy_o); end
        #3 arst_n = 1'b0;
        #1;
        n_checks++;
        if (busy_o !== 1'b0 || div_o !== 32'd868) begin
            n_fail++; $display("FAIL rearm_async_reset: busy_o=%0b div_o=%0d, expected busy 0 div 868", busy_o, div_o);
        end
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse_start();
        exp_q.push_back('{1'b0, 32'd50});
        send_byte(8'h55, 50);
        wait_event(100, ok);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rearm_event: no event seen, expected div=%0d", e.div);
        end else begin
            o = obs_q.pop_front();
            if (o.err !== e.err || o.val !== !e.err || o.div !== e.div) begin
                n_fail++; $display("FAIL rearm_event: err=%0b valid=%0b div=%0d, expected err=%0b div=%0d", o.err, o.val, o.div, e.err, e.div);
            end
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || div_o !== 32'd50) begin
            n_fail++; $display("FAIL rearm_final: events=%0d div_o=%0d, expected 0 events div 50", obs_q.size(), div_o);
        end
    endtask

    initial begin
        test_reset();
        test_measure_80();
        test_measure_83_and_bad_pattern();
        test_min_div();
        test_tolerance_rounding();
        test_rx_low_armed();
        test_back_to_back();
        test_timeout();
        test_reset_rearm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
